// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and defaults for the sonar scan scheduler.
// The default timing constants are also used by the register block so both
// sides agree on reset values.
package sonar_pkg;

  // Scheduler states, one channel in flight at a time
  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT,
    S_MEAS,
    S_GUARD,
    S_NEXT
  } sonar_state_e;

  // Width value reported on no-echo or stuck-high echo
  localparam logic [15:0] WIDTH_MAX = 16'hFFFF;

  // Default timing in clk cycles
  localparam int DEF_TRIG_CYCLES = 500;
  localparam int DEF_TIMEOUT     = 30000;
  localparam int DEF_GUARD       = 3000;

endpackage

// File: rtl/sonar_echo_sync.sv
// sonar_echo_sync: per-channel echo conditioning. Optional 2-flop
// synchronizer (build macro SONAR_SYNC_EN), then a sample register and a
// previous-value register that together produce single-cycle rise/fall.
// Pin-to-edge latency is 1 cycle without the synchronizer, 3 with it.
module sonar_echo_sync
  import sonar_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic rise,
  output logic fall
);

  logic echo_s;
  logic cur_q;
  logic prv_q;

`ifdef SONAR_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage metastability filter for an asynchronous echo pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], echo};
  end

  assign echo_s = sync_q[1];
`else
  assign echo_s = echo;
`endif

  // Sample register plus its delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= 1'b0;
      prv_q <= 1'b0;
    end else begin
      cur_q <= echo_s;
      prv_q <= cur_q;
    end
  end

  assign rise = cur_q & ~prv_q;
  assign fall = ~cur_q & prv_q;

endmodule

// File: rtl/sonar_scan_scheduler.sv
// sonar_scan_scheduler: walks the masked channels lowest-first through one
// shared echo timer: trigger pulse, wait for echo, time echo width, guard gap.
// One tagged measurement per channel per scan. Build macro SONAR_SYNC_EN
// (handled in sonar_echo_sync) adds a synchronizer on every echo input.
module sonar_scan_scheduler
  import sonar_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int TRIG_CYCLES = DEF_TRIG_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int GUARD       = DEF_GUARD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    start,
  input  logic [NCH-1:0]          chan_mask,
  input  logic [NCH-1:0]          echo_i,
  output logic [NCH-1:0]          trig_o,
  output logic                    busy,
  output logic                    meas_valid,
  output logic [$clog2(NCH)-1:0]  meas_chan,
  output logic [15:0]             meas_width,
  output logic                    meas_timeout,
  output logic                    scan_done
);

  localparam int CW = $clog2(NCH);

  sonar_state_e   state;
  logic [15:0]    cnt;        // shared by TRIG, WAIT, MEAS (as width) and GUARD
  logic [CW-1:0]  cur;
  logic [NCH-1:0] scan_mask;
  logic [NCH-1:0] rem_mask;
  logic [NCH-1:0] rise_v;
  logic [NCH-1:0] fall_v;
  logic           rise_sel;
  logic           fall_sel;

  // Index of the lowest set bit; zero for an empty mask
  function automatic logic [CW-1:0] lsb_idx(input logic [NCH-1:0] m);
    lsb_idx = '0;
    for (int i = NCH - 1; i >= 0; i--)
      if (m[i]) lsb_idx = CW'(i);
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [CW-1:0] idx);
    onehot = '0;
    for (int i = 0; i < NCH; i++)
      if (CW'(i) == idx) onehot[i] = 1'b1;
  endfunction

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sonar_echo_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .echo  (echo_i[g]),
      .rise  (rise_v[g]),
      .fall  (fall_v[g])
    );
  end

  // Only the channel being serviced can produce edges
  assign rise_sel = rise_v[cur];
  assign fall_sel = fall_v[cur];

  // Channels still pending once the current one is retired
  assign rem_mask = scan_mask & ~onehot(cur);

  // Scan sequencer; all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cur          <= '0;
      scan_mask    <= '0;
      trig_o       <= '0;
      busy         <= 1'b0;
      meas_valid   <= 1'b0;
      meas_chan    <= '0;
      meas_width   <= '0;
      meas_timeout <= 1'b0;
      scan_done    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      scan_done  <= 1'b0;
      if (!enable && state != S_IDLE) begin
        // abort: partial result is dropped, nothing reported
        state  <= S_IDLE;
        trig_o <= '0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && enable && !busy) begin
              scan_mask <= chan_mask;
              if (chan_mask == '0) begin
                scan_done <= 1'b1;
              end else begin
                cur    <= lsb_idx(chan_mask);
                trig_o <= onehot(lsb_idx(chan_mask));
                busy   <= 1'b1;
                cnt    <= '0;
                state  <= S_TRIG;
              end
            end
          end
          S_TRIG: begin
            if (cnt == 16'(TRIG_CYCLES - 1)) begin
              trig_o <= '0;
              cnt    <= '0;
              state  <= S_WAIT;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_WAIT: begin
            if (rise_sel) begin
              cnt   <= 16'd1;
              state <= S_MEAS;
            end else if (cnt == 16'(TIMEOUT - 1)) begin
              meas_valid   <= 1'b1;
              meas_chan    <= cur;
              meas_width   <= WIDTH_MAX;
              meas_timeout <= 1'b1;
              cnt          <= '0;
              state        <= S_GUARD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_MEAS: begin
            if (fall_sel) begin
              meas_valid   <= 1'b1;
              meas_chan    <= cur;
              meas_width   <= cnt;
              meas_timeout <= 1'b0;
              cnt          <= '0;
              state        <= S_GUARD;
            end else if (cnt == WIDTH_MAX - 16'd1) begin
              // echo stuck high: report saturation without waiting for the fall
              meas_valid   <= 1'b1;
              meas_chan    <= cur;
              meas_width   <= WIDTH_MAX;
              meas_timeout <= 1'b1;
              cnt          <= '0;
              state        <= S_GUARD;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          S_GUARD: begin
            if (cnt == 16'(GUARD - 1)) state <= S_NEXT;
            else                       cnt   <= cnt + 16'd1;
          end
          S_NEXT: begin
            scan_mask <= rem_mask;
            if (rem_mask != '0) begin
              cur    <= lsb_idx(rem_mask);
              trig_o <= onehot(lsb_idx(rem_mask));
              cnt    <= '0;
              state  <= S_TRIG;
            end else begin
              scan_done <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: begin
            state  <= S_IDLE;
            trig_o <= '0;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// tb_sonar_scan_scheduler: random and directed scans against a reference
// model that derives each channel's expected report from its echo delay and
// width. Shortened timing parameters keep runtime low.
module tb_sonar_scan_scheduler;

  localparam int NCH    = 4;
  localparam int TRIG_C = 20;
  localparam int TMO    = 300;
  localparam int GRD    = 40;
  localparam int CW     = $clog2(NCH);
`ifdef SONAR_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           start = 1'b0;
  logic [NCH-1:0] chan_mask = '0;
  logic [NCH-1:0] echo_i = '0;
  logic [NCH-1:0] trig_o;
  logic           busy, meas_valid, meas_timeout, scan_done;
  logic [CW-1:0]  meas_chan;
  logic [15:0]    meas_width;

  sonar_scan_scheduler #(
    .NCH(NCH), .TRIG_CYCLES(TRIG_C), .TIMEOUT(TMO), .GUARD(GRD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .chan_mask(chan_mask), .echo_i(echo_i), .trig_o(trig_o), .busy(busy),
    .meas_valid(meas_valid), .meas_chan(meas_chan), .meas_width(meas_width),
    .meas_timeout(meas_timeout), .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // cycle index = number of posedges so far
  always begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ---------------- echo driver (reacts to trigger falling) ----------------
  int dly [NCH];
  int wid [NCH];
  int cd  [NCH];
  int hi  [NCH];
  int fall_cyc [NCH];
  bit armed [NCH];
  logic [NCH-1:0] kill  = '0;
  logic [NCH-1:0] noise = '0;
  logic [NCH-1:0] dq    = '0;

  always begin
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (kill[c]) begin
        echo_i[c] = 1'b0;
        armed[c]  = 1'b0;
      end else if (noise[c]) begin
        echo_i[c] = 1'($urandom_range(0, 1));
      end else begin
        if (dq[c] && !trig_o[c] && wid[c] > 0) begin
          armed[c] = 1'b1;
          cd[c]    = dly[c];
        end
        if (armed[c]) begin
          if (cd[c] == 0) begin
            armed[c]  = 1'b0;
            echo_i[c] = 1'b1;
            hi[c]     = wid[c];
          end else begin
            cd[c]--;
          end
        end else if (echo_i[c]) begin
          hi[c]--;
          if (hi[c] == 0) begin
            echo_i[c]   = 1'b0;
            fall_cyc[c] = cyc;
          end
        end
      end
    end
    dq = trig_o;
  end

  // ---------------- output monitor ----------------
  int rq_chan[$], rq_cyc[$];
  int mq_chan[$], mq_w[$], mq_to[$], mq_cyc[$];
  int n_done = 0;
  bit len_chk = 1'b1;
  logic [NCH-1:0] tp = '0;
  int tlen [NCH];

  always begin
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (trig_o[c]) begin
        if (!tp[c]) begin
          rq_chan.push_back(c);
          rq_cyc.push_back(cyc);
          chk("trig_onehot", $onehot0(trig_o), 1);
          chk("busy_with_trig", busy, 1);
        end
        tlen[c]++;
      end else if (tp[c]) begin
        if (len_chk) chk("trig_len", tlen[c], TRIG_C);
        tlen[c] = 0;
      end
    end
    tp = trig_o;
    if (meas_valid) begin
      mq_chan.push_back(int'(meas_chan));
      mq_w.push_back(int'(meas_width));
      mq_to.push_back(int'(meas_timeout));
      mq_cyc.push_back(cyc);
    end
    if (scan_done) begin
      n_done++;
      chk("busy_at_done", busy, 0);
    end
  end

  task automatic set_ch(input int c, input int d, input int w);
    dly[c] = d;
    wid[c] = w;
  endtask

  task automatic clr_ch();
    for (int c = 0; c < NCH; c++) set_ch(c, 0, 0);
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, ":trig"},  trig_o, 0);
    chk({nm, ":busy"},  busy, 0);
    chk({nm, ":mv"},    meas_valid, 0);
    chk({nm, ":mchan"}, meas_chan, 0);
    chk({nm, ":mw"},    meas_width, 0);
    chk({nm, ":mto"},   meas_timeout, 0);
    chk({nm, ":done"},  scan_done, 0);
  endtask

  // One scan: start, wait for scan_done, then compare against the model
  task automatic run_scan(input logic [NCH-1:0] m, input string nm);
    int mb, rb, db, t, idx, ew, eto, last_w, last_c;
    logic [NCH-1:0] lo;
    bit measured;
    mb = mq_chan.size(); rb = rq_chan.size(); db = n_done;
    last_w = 0; last_c = 0;
    chan_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chan_mask = NCH'($urandom);
    lo = m & (~m + 1'b1);
    chk({nm, ":trig_first"}, trig_o, lo);
    chk({nm, ":busy_first"}, busy, m != '0);
    if (m == '0) chk({nm, ":done_now"}, scan_done, 1);
    t = 0;
    while (n_done == db && t < 90000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, ":done_count"}, n_done - db, 1);
    chk({nm, ":n_meas"}, mq_chan.size() - mb, $countones(m));
    chk({nm, ":n_trig"}, rq_chan.size() - rb, $countones(m));
    idx = 0;
    for (int c = 0; c < NCH; c++) begin
      if (m[c]) begin
        measured = (wid[c] > 0) && (dly[c] + L <= TMO - 1);
        if (measured && wid[c] < 65535) begin ew = wid[c]; eto = 0; end
        else begin ew = 65535; eto = 1; end
        if (mb + idx < mq_chan.size()) begin
          chk({nm, ":chan"},  mq_chan[mb+idx], c);
          chk({nm, ":width"}, mq_w[mb+idx], ew);
          chk({nm, ":tmo"},   mq_to[mb+idx], eto);
          if (eto == 0) chk({nm, ":lat"}, mq_cyc[mb+idx], fall_cyc[c] + L + 1);
          if (idx > 0 && rb + idx < rq_cyc.size())
            chk({nm, ":guard_gap"}, rq_cyc[rb+idx], mq_cyc[mb+idx-1] + GRD + 1);
        end
        if (rb + idx < rq_chan.size()) chk({nm, ":trig_chan"}, rq_chan[rb+idx], c);
        last_w = ew;
        last_c = c;
        idx++;
      end
    end
    if (m != '0) begin
      chk({nm, ":hold_w"}, meas_width, last_w);
      chk({nm, ":hold_c"}, meas_chan, last_c);
    end
    noise = '0;
    kill = '1;
    repeat (2) @(negedge clk);
    kill = '0;
    @(negedge clk);
  endtask

  logic [NCH-1:0] rm;
  int mb0, rb0, db0, t0;

  initial begin
    clr_ch();
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // two channels with clean echoes
    set_ch(0, 10, 1200); set_ch(2, 37, 800);
    run_scan(4'b0101, "two_ch");

    // empty mask
    clr_ch();
    run_scan(4'b0000, "empty");

    // no echo
    clr_ch();
    run_scan(4'b0010, "no_echo");

    // timeout boundary and width-1 echo
    set_ch(0, TMO - 1 - L, 30);
    set_ch(1, TMO - L, 5);
    set_ch(2, 0, 1);
    set_ch(3, 3, 2);
    run_scan(4'b1111, "edges");

    // random scans with noise on unselected channels
    for (int r = 0; r < 6; r++) begin
      rm = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 9))
          0:       set_ch(c, TMO - L - $urandom_range(0, 1), $urandom_range(1, 150));
          1:       set_ch(c, $urandom_range(0, 60), 0);
          default: set_ch(c, $urandom_range(0, 60), $urandom_range(1, 150));
        endcase
      end
      noise = ~rm & NCH'($urandom);
      run_scan(rm, "rnd");
    end

    // abort during MEAS; start while busy is ignored
    clr_ch();
    set_ch(1, 3, 150);
    mb0 = mq_chan.size(); rb0 = rq_chan.size(); db0 = n_done;
    chan_mask = 4'b0010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chan_mask = 4'b0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = 0;
    while (!echo_i[1] && t0 < 500) begin
      @(negedge clk);
      t0++;
    end
    chk("abort:echo_seen", echo_i[1], 1);
    repeat (L + 10) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort:trig", trig_o, 0);
    chk("abort:busy", busy, 0);
    repeat (300) @(negedge clk);
    chk("abort:no_meas", mq_chan.size() - mb0, 0);
    chk("abort:no_done", n_done - db0, 0);
    chk("abort:one_trig", rq_chan.size() - rb0, 1);
    enable = 1'b1;
    @(negedge clk);

    // echo stuck high on ch3 saturates
    clr_ch();
    set_ch(3, 5, 1000000);
    run_scan(4'b1000, "stuck");

    // asynchronous reset in the middle of a trigger pulse
    clr_ch();
    len_chk = 1'b0;
    chan_mask = 4'b0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_trig:trig_hi", trig_o, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk_rst("mid_trig");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    len_chk = 1'b1;

    // first scenario again after reset
    set_ch(0, 10, 1200); set_ch(2, 37, 800);
    run_scan(4'b0101, "two_ch_again");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sonar_scan_scheduler.md
# sonar_scan_scheduler

Sequences up to NCH ultrasonic ranging channels through one shared echo-timing datapath, one channel at a time, so that adjacent sensors cannot crosstalk. It sits between the theremin register block and the sensor pins. It issues trigger pulses, times echo widths, enforces a guard interval between channels, and emits one tagged measurement per channel per scan.

## Interface
- NCH, 4: number of sensor channels (2..8).
- TRIG_CYCLES, 500: trigger pulse width in clk cycles.
- TIMEOUT, 30000: cycles to wait for an echo rising edge before declaring no-echo.
- GUARD, 3000: idle cycles after each channel before the next trigger.
- Reset rst_n, asynchronous, active-low; clock clk.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; low aborts any scan and holds IDLE.
- start  in  1  one-cycle request to run one scan.
- chan_mask  in  NCH  channels included in the scan; sampled on accepted start.
- echo_i  in  NCH  raw echo inputs, one per channel.
- trig_o  out  NCH  trigger outputs, at most one bit high.
- busy  out  1  high from accepted start until scan_done.
- meas_valid  out  1  one-cycle pulse; measurement fields are valid.
- meas_chan  out  $clog2(NCH)  channel index of the measurement.
- meas_width  out  16  echo high-time in cycles, saturating.
- meas_timeout  out  1  with meas_valid: no echo, or echo stuck high.
- scan_done  out  1  one-cycle pulse at end of scan.

## Operation
- States: IDLE, TRIG, WAIT, MEAS, GUARD, NEXT.
- IDLE: start && enable && !busy latches chan_mask into scan_mask. If scan_mask==0, pulse scan_done next cycle and stay IDLE. Otherwise select the lowest set bit and go to TRIG.
- TRIG: trig_o[cur] high for exactly TRIG_CYCLES cycles. The counter clears on entry. Then go to WAIT.
- WAIT: the counter counts from 0. A rising edge of echo[cur] goes to MEAS with width=1. If the counter reaches TIMEOUT, report width=16'hFFFF, timeout=1, and go to GUARD.
- MEAS: width increments while echo is high, saturating at 16'hFFFF. A falling edge reports width, timeout=0. If width saturates, report 16'hFFFF, timeout=1, without waiting for the falling edge.
- Report: meas_valid pulses for one cycle on the same edge the FSM enters GUARD. meas_chan, meas_width and meas_timeout hold until the next report.
- GUARD: count GUARD cycles, echo ignored, then go to NEXT.
- NEXT: clear bit cur in scan_mask. If any bit remains, select the next-higher set bit and go to TRIG. Otherwise pulse scan_done, drop busy, and go to IDLE.
- Edges are detected only on the selected channel. Echoes on unselected channels are ignored.
- start while busy is ignored; a request is not queued.
- enable low in any non-IDLE state: next cycle trig_o=0, busy=0, state=IDLE. No meas_valid or scan_done is produced; a partial result is discarded.
- Reset values: trig_o=0, busy=0, meas_valid=0, meas_chan=0, meas_width=0, meas_timeout=0, scan_done=0, state=IDLE.

## Timing
- The cycle after an accepted start: busy=1 and trig_o[first] rises.
- trig_o is high exactly TRIG_CYCLES cycles.
- Echo path latency L from pin to edge detect: L=1 without sync, L=3 with sync (see Configuration).
- meas_valid is registered: it asserts L+1 cycles after the echo pin falls.
- The next trigger rises GUARD+1 cycles after meas_valid.
- scan_done asserts 1 cycle after the final GUARD ends. busy falls in the same cycle as scan_done.
- The timeout boundary is exact: an echo rising on counter value TIMEOUT−1 is measured; at TIMEOUT the channel is reported as timed out.

## Configuration
- SONAR_SYNC_EN defined: each echo_i passes a 2-flop synchronizer before the edge-detect register (L=3).
- SONAR_SYNC_EN undefined: echo_i feeds the edge-detect register directly (L=1). This is for benches and for already-synchronous sources.
- Measured widths are identical in both builds; only the latency differs.

## Structure
- Package sonar_pkg holds:
  - the state enum;
  - WIDTH_MAX=16'hFFFF;
  - default TRIG_CYCLES, TIMEOUT and GUARD constants, shared with the register block.
- Sub-module sonar_echo_sync, one per channel, contains the optional synchronizer, the previous-value flop, and rise/fall outputs.
- The scheduler muxes rise/fall by cur.
- A single shared 16-bit counter serves TRIG, WAIT, MEAS and GUARD.

## Test plan
- mask=4'b0101, ch0 echo high 1200 cycles, ch2 echo 800: meas_valid twice, chan 0 width 1200 and chan 2 width 800, timeout=0, then scan_done. ch1 and ch3 are never triggered.
- mask=4'b0010, no echo: trig_o[1] is 500 cycles; after 30000 wait cycles meas_valid with width FFFF, timeout=1.
- Echo held high indefinitely on ch3: width saturates, and FFFF with timeout=1 is reported without a falling edge.
- mask=0 on start: scan_done is pulsed the next cycle; trig_o and busy are never asserted.
- enable dropped during MEAS on ch1: trig_o=0 and IDLE next cycle, with no meas_valid and no scan_done. start is ignored while busy.
- rst_n asserted mid-TRIG: all outputs are at reset values immediately. Repeat the first scenario with SONAR_SYNC_EN defined: widths are identical and meas_valid is 2 cycles later.
